// File: rtl/conv_enc_framer_if.sv
// Byte-stream handshake into the framer: word, valid, last-of-frame and ready.
interface conv_enc_framer_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/conv_enc_framer.sv
// Framer in front of conv_enc: loads both generator masks, then serialises
// words MSB-first onto data_in and flushes the encoder with N-1 zero tail
// bits after the last word of each frame.
module conv_enc_framer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_enc_framer_if.slave     in_if,
  input  logic [N-1:0]         mask0_cfg,
  input  logic [N-1:0]         mask1_cfg,
  input  logic                 cfg_update,
  output logic [1:0]           load_mask,
  output logic [N-1:0]         mask,
  output logic                 data_in,
  output logic                 bit_valid,
  output logic                 frame_start,
  output logic                 tail,
  output logic                 err_underrun,
  output logic                 busy
);

  // Counter must reach both W-1 (data bits) and N-2 (tail bits).
  localparam int CW = $clog2((W > N) ? W : N) + 1;

  typedef enum logic [2:0] {CFG0, CFG1, IDLE, SHIFT, HOLD, TAIL} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    shreg_reg, shreg_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            last_reg, last_next;
  logic            data_in_reg, data_in_next;
  logic            bit_valid_reg, bit_valid_next;
  logic            frame_start_reg, frame_start_next;
  logic            tail_reg, tail_next;
  logic            err_reg, err_next;
  logic            in_ready_c;
  logic            accept;

  // Next-state, handshake and mask-load decode; bit outputs are computed one
  // cycle early so they appear registered right after the accepting edge.
  always_comb begin
    state_next       = state_reg;
    shreg_next       = shreg_reg;
    cnt_next         = cnt_reg;
    last_next        = last_reg;
    data_in_next     = 1'b0;
    bit_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    tail_next        = 1'b0;
    err_next         = 1'b0;
    in_ready_c       = 1'b0;
    load_mask        = 2'b00;
    mask             = '0;
    accept           = 1'b0;

    case (state_reg)
      CFG0: begin
        load_mask  = 2'b01;
        mask       = mask0_cfg;
        state_next = CFG1;
      end
      CFG1: begin
        load_mask  = 2'b10;
        mask       = mask1_cfg;
        state_next = IDLE;
      end
      IDLE: begin
        in_ready_c = !cfg_update;
        if (cfg_update) begin
          state_next = CFG0;
        end else if (in_if.in_valid) begin
          accept           = 1'b1;
          frame_start_next = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_reg == CW'(W - 1)) begin
          // LSB on the wire: chain the next word, flush, or fall into a gap.
          in_ready_c = !last_reg;
          if (last_reg) begin
            state_next     = TAIL;
            cnt_next       = '0;
            bit_valid_next = 1'b1;
            tail_next      = 1'b1;
          end else if (in_if.in_valid) begin
            accept = 1'b1;
          end else begin
            state_next = HOLD;
            err_next   = 1'b1;
          end
        end else begin
          data_in_next   = shreg_reg[W-1];
          bit_valid_next = 1'b1;
          shreg_next     = {shreg_reg[W-2:0], 1'b0};
          cnt_next       = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        in_ready_c = 1'b1;
        if (in_if.in_valid) begin
          accept = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      TAIL: begin
        if (cnt_reg == CW'(N - 2)) begin
          state_next = IDLE;
        end else begin
          cnt_next       = cnt_reg + 1'b1;
          bit_valid_next = 1'b1;
          tail_next      = 1'b1;
        end
      end
      default: state_next = CFG0;
    endcase

    // An accepted word puts its MSB out immediately; the rest waits in shreg.
    if (accept) begin
      state_next     = SHIFT;
      data_in_next   = in_if.in_data[W-1];
      bit_valid_next = 1'b1;
      shreg_next     = {in_if.in_data[W-2:0], 1'b0};
      cnt_next       = '0;
      last_next      = in_if.in_last;
    end
  end

  // State and registered bit outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= CFG0;
      shreg_reg       <= '0;
      cnt_reg         <= '0;
      last_reg        <= 1'b0;
      data_in_reg     <= 1'b0;
      bit_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      tail_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shreg_reg       <= shreg_next;
      cnt_reg         <= cnt_next;
      last_reg        <= last_next;
      data_in_reg     <= data_in_next;
      bit_valid_reg   <= bit_valid_next;
      frame_start_reg <= frame_start_next;
      tail_reg        <= tail_next;
      err_reg         <= err_next;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign data_in        = data_in_reg;
  assign bit_valid      = bit_valid_reg;
  assign frame_start    = frame_start_reg;
  assign tail           = tail_reg;
  assign err_underrun   = err_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: doc/conv_enc_framer.md
# conv_enc_framer

Upstream framer for `conv_enc`. It accepts bytes on a valid/ready stream, serialises them MSB-first into the encoder's one-bit `data_in`, and appends N-1 zero tail bits at the end of each frame to flush the encoder. It also sequences the two generator-mask loads after reset and on request. Its outputs connect directly to the `conv_enc` ports of the same names.

## Interface
- `N`, default 4: encoder register length (constraint length + 1). It must equal the `N` of the attached `conv_enc`. The tail is N-1 bits.
- `W`, default 8: input word width in bits, W ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_data`  in  W: input word, MSB sent first.
- `in_valid`  in  1: `in_data` / `in_last` are valid.
- `in_last`  in  1: the word is the last of the frame.
- `in_ready`  out  1: framer accepts the word this cycle (combinational from state and counter).
- `mask0_cfg`, `mask1_cfg`  in  N each: generator masks, with a leading 1 prepended.
- `cfg_update`  in  1: request a mask reload.
- `load_mask`  out  2: to the encoder. 01 loads mask0; 10 loads mask1.
- `mask`  out  N: to the encoder.
- `data_in`  out  1: serial bit to the encoder (registered).
- `bit_valid`  out  1: `data_in` is a frame bit, either data or tail (registered).
- `frame_start`  out  1: high with the first data bit of the frame (registered).
- `tail`  out  1: high during tail bits (registered).
- `err_underrun`  out  1: one-cycle pulse per gap bit (registered).
- `busy`  out  1: state is not IDLE.

## Operation
- **States:** CFG0, CFG1, IDLE, SHIFT, HOLD, TAIL. The reset state is CFG0.
- **CFG0:**
  - `load_mask`=01 and `mask`=`mask0_cfg`.
  - Next state is CFG1.
- **CFG1:**
  - `load_mask`=10 and `mask`=`mask1_cfg`.
  - Next state is IDLE.
- **In all other states:** `load_mask`=00 and `mask`=0.
- **IDLE:**
  - `in_ready`=1.
  - `cfg_update`=1 goes to CFG0 and takes priority: `in_ready` is 0 that cycle.
  - Otherwise, if `in_valid`, the word is latched into the shift register, `last_q` is set to `in_last`, and the state goes to SHIFT.
  - `data_in`=0 and `bit_valid`=0.
- **SHIFT:**
  - Each cycle emits `shreg[W-1]` with `bit_valid`=1 and shifts left. The bit counter counts 0..W-1.
  - `in_ready`=1 only when counter=W-1 and `last_q`=0.
  - At counter=W-1:
    - `last_q`=1 goes to TAIL.
    - If a word is accepted, its bits follow seamlessly and the state stays in SHIFT.
    - Otherwise the state goes to HOLD.
- **HOLD (mid-frame underrun):**
  - `in_ready`=1.
  - Each cycle without a word emits `data_in`=0, `bit_valid`=0 and pulses `err_underrun`=1. The encoder shifts in these zeros.
  - On acceptance the state goes to SHIFT.
- **TAIL:**
  - Emits N-1 bits with `data_in`=0, `bit_valid`=1 and `tail`=1.
  - Then goes to IDLE.
- **`cfg_update` outside IDLE** is ignored and dropped, not queued.
- **Frames:**
  - `frame_start`=1 only on the first bit after acceptance from IDLE.
  - A one-word frame with `in_last`=1 gives W data bits followed by N-1 tail bits.
- **Reset:**
  - Asserting `reset` mid-frame aborts the frame immediately.
  - On release, the framer reruns CFG0 and CFG1.

## Timing
- **Reset values:**
  - `load_mask`=01, `mask`=`mask0_cfg`, `busy`=1.
  - `data_in`, `bit_valid`, `frame_start`, `tail`, `err_underrun` and `in_ready` are all 0.
- **Mask loading:**
  - First edge after reset release: the encoder loads mask0.
  - Second edge: the encoder loads mask1.
  - `in_ready` first rises in the 3rd cycle after release.
- **Latency:** a word accepted at edge t puts its MSB on `data_in` during cycle t+1 (after edge t). Its LSB is at t+W.
- **Throughput:** back-to-back words give a continuous bit stream, one bit per clock, with no bubbles.
- **Tail timing:** after the last LSB at cycle t+W, the tail occupies cycles t+W+1 .. t+W+N-1. IDLE follows, with at least one idle cycle where `data_in`=0 before the next frame's first bit.
- **Output timing:** all bit outputs change only after the rising edge, so the encoder samples them stably on the next edge.

## Test plan
- **Reset then mask load:** release `reset` with `mask0_cfg`=4'o17 and `mask1_cfg`=4'o13 → `load_mask` is 01 then 10, `mask` is 1111 then 1011, `in_ready` rises in cycle 3.
- **Single frame:** W=8, N=4, send 0xA5 with `in_last` → `data_in` is 1,0,1,0,0,1,0,1,0,0,0. `bit_valid` is high for 11 cycles, `frame_start` on bit 0, `tail` on the last 3. The encoder output matches the reference model.
- **Back-to-back frame:** send 0x0F then 0xF0 (last) with `in_valid` held high → 16 contiguous bits 0000111111110000, then a 3-bit tail, with no gap.
- **Underrun:** send 0x80, drop `in_valid` for 2 cycles, then send 0x01 (last) → `err_underrun` pulses twice and two zero bits with `bit_valid`=0 appear between the words.
- **Reload:** `cfg_update` during SHIFT is ignored. `cfg_update` with `in_valid` in IDLE → CFG0 and CFG1 run first, then the word is accepted.
- **Mid-frame reset:** assert `reset` at bit 3 → outputs go to their reset values asynchronously. After release the masks reload and a new frame encodes correctly.
